// File: rtl/rx_5b4b_deframer.sv
// 5B/4B receive deframer: J/K alignment, symbol-pair decode, word assembly, sof/eof framing,
// length and idle-timeout checks. Define RX_CRC_EN to add a CRC-16/CCITT-FALSE residue check.
module rx_5b4b_deframer #(
  parameter int NIB_PER_WORD = 2,
  parameter int MAX_LEN      = 256,
  parameter int TO_CYC       = 64,
  localparam int DATA_W      = 4 * NIB_PER_WORD,
  localparam int CNT_W       = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_vld,
  input  logic              rx_en,
  output logic              lock,
  output logic              frame,
  output logic [DATA_W-1:0] data_o,
  output logic              data_vld,
  output logic              sof,
  output logic              eof,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [CNT_W-1:0]  word_cnt
);
  localparam int NIB_W = (NIB_PER_WORD > 2) ? $clog2(NIB_PER_WORD) : 1;
  localparam int TO_W  = $clog2(TO_CYC + 1);

  localparam logic [9:0] SYM_JK = 10'b11000_10001;
  localparam logic [9:0] SYM_TT = 10'b01101_01101;
  localparam logic [4:0] SYM_I  = 5'b11111;

  typedef enum logic {S_IDLE, S_RECV} state_t;
  typedef enum logic [2:0] {
    E_NONE = 3'd0, E_SYM = 3'd1, E_JK  = 3'd2, E_IDLE = 3'd3,
    E_LEN  = 3'd4, E_TT  = 3'd5, E_TO  = 3'd6, E_CRC  = 3'd7
  } err_t;

  // Returns {valid, nibble} for a 5-bit data symbol.
  function automatic logic [4:0] dec5(input logic [4:0] s);
    case (s)
      5'b11110: return 5'h10;  5'b01001: return 5'h11;
      5'b10100: return 5'h12;  5'b10101: return 5'h13;
      5'b01010: return 5'h14;  5'b01011: return 5'h15;
      5'b01110: return 5'h16;  5'b01111: return 5'h17;
      5'b10010: return 5'h18;  5'b10011: return 5'h19;
      5'b10110: return 5'h1A;  5'b10111: return 5'h1B;
      5'b11010: return 5'h1C;  5'b11011: return 5'h1D;
      5'b11100: return 5'h1E;  5'b11101: return 5'h1F;
      default:  return 5'h00;
    endcase
  endfunction

  state_t             state, state_n;
  logic [9:0]         sr, sr_n;
  logic [3:0]         bit_cnt, bit_cnt_n;
  logic [NIB_W-1:0]   nib_idx, nib_idx_n;
  logic [DATA_W-1:0]  acc, acc_n, word_asm;
  logic [TO_W-1:0]    to_cnt, to_cnt_n;
  logic               lock_n, frame_n, data_vld_n, sof_n, eof_n, err_n;
  logic [DATA_W-1:0]  data_o_n;
  err_t               err_code_q, err_code_n;
  logic [CNT_W-1:0]   word_cnt_n;
  logic [4:0]         hi_dec, lo_dec;
  logic               start, go_idle, raise;
  err_t               code;
`ifdef RX_CRC_EN
  logic [15:0]        crc, crc_n;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [DATA_W-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--)
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction
`endif

  assign err_code = err_code_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_n    = state;
    sr_n       = bit_vld ? {sr[8:0], bit_in} : sr;
    bit_cnt_n  = bit_cnt;
    nib_idx_n  = nib_idx;
    acc_n      = acc;
    to_cnt_n   = to_cnt;
    lock_n     = lock;
    frame_n    = frame;
    data_o_n   = data_o;
    data_vld_n = 1'b0;
    sof_n      = 1'b0;
    eof_n      = 1'b0;
    err_n      = 1'b0;
    err_code_n = err_code_q;
    word_cnt_n = word_cnt;
    start      = 1'b0;
    go_idle    = 1'b0;
    raise      = 1'b0;
    code       = E_NONE;
    hi_dec     = dec5(sr_n[9:5]);
    lo_dec     = dec5(sr_n[4:0]);
    word_asm   = DATA_W'(acc << 8) | DATA_W'({hi_dec[3:0], lo_dec[3:0]});
`ifdef RX_CRC_EN
    crc_n      = crc;
`endif

    if (!rx_en) begin
      go_idle = 1'b1;
    end else begin
      case (state)
        S_IDLE: if (bit_vld && sr_n == SYM_JK) start = 1'b1;
        S_RECV: begin
          if (bit_vld) begin
            to_cnt_n  = '0;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) begin
              bit_cnt_n = '0;
              if (sr_n == SYM_TT) begin
                go_idle = 1'b1;
                if (nib_idx != '0) begin
                  raise = 1'b1;
                  code  = E_TT;
                end else begin
                  eof_n = 1'b1;
`ifdef RX_CRC_EN
                  // An empty frame carries no CRC bytes, so only non-empty frames are checked.
                  if (word_cnt != '0 && crc != 16'h0000) begin
                    raise = 1'b1;
                    code  = E_CRC;
                  end
`endif
                end
              end else if (sr_n == SYM_JK) begin
                raise = 1'b1;
                code  = E_JK;
                start = 1'b1;
              end else if (sr_n[9:5] == SYM_I || sr_n[4:0] == SYM_I) begin
                raise   = 1'b1;
                code    = E_IDLE;
                go_idle = 1'b1;
              end else if (!hi_dec[4] || !lo_dec[4]) begin
                raise   = 1'b1;
                code    = E_SYM;
                go_idle = 1'b1;
              end else begin
                acc_n = word_asm;
                if (nib_idx == NIB_W'(NIB_PER_WORD - 2)) begin
                  nib_idx_n = '0;
                  if (word_cnt == CNT_W'(MAX_LEN)) begin
                    raise   = 1'b1;
                    code    = E_LEN;
                    go_idle = 1'b1;
                  end else begin
                    data_vld_n = 1'b1;
                    data_o_n   = word_asm;
                    sof_n      = (word_cnt == '0);
                    word_cnt_n = word_cnt + CNT_W'(1);
`ifdef RX_CRC_EN
                    crc_n      = crc_upd(crc, word_asm);
`endif
                  end
                end else begin
                  nib_idx_n = nib_idx + NIB_W'(2);
                end
              end
            end
          end else if (to_cnt == TO_W'(TO_CYC - 1)) begin
            raise   = 1'b1;
            code    = E_TO;
            go_idle = 1'b1;
          end else begin
            to_cnt_n = to_cnt + TO_W'(1);
          end
        end
        default: go_idle = 1'b1;
      endcase
    end

    // A restart clears the frame counters but keeps the error raised by the same pair.
    if (start) begin
      state_n    = S_RECV;
      lock_n     = 1'b1;
      frame_n    = 1'b1;
      word_cnt_n = '0;
      err_code_n = E_NONE;
      bit_cnt_n  = '0;
      nib_idx_n  = '0;
      to_cnt_n   = '0;
`ifdef RX_CRC_EN
      crc_n      = 16'hFFFF;
`endif
    end
    if (raise) begin
      err_n      = 1'b1;
      err_code_n = code;
    end
    if (go_idle) begin
      state_n = S_IDLE;
      lock_n  = 1'b0;
      frame_n = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sr         <= 10'h3FF;
      bit_cnt    <= '0;
      nib_idx    <= '0;
      acc        <= '0;
      to_cnt     <= '0;
      lock       <= 1'b0;
      frame      <= 1'b0;
      data_o     <= '0;
      data_vld   <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      err        <= 1'b0;
      err_code_q <= E_NONE;
      word_cnt   <= '0;
`ifdef RX_CRC_EN
      crc        <= 16'hFFFF;
`endif
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      bit_cnt    <= bit_cnt_n;
      nib_idx    <= nib_idx_n;
      acc        <= acc_n;
      to_cnt     <= to_cnt_n;
      lock       <= lock_n;
      frame      <= frame_n;
      data_o     <= data_o_n;
      data_vld   <= data_vld_n;
      sof        <= sof_n;
      eof        <= eof_n;
      err        <= err_n;
      err_code_q <= err_code_n;
      word_cnt   <= word_cnt_n;
`ifdef RX_CRC_EN
      crc        <= crc_n;
`endif
    end
  end
endmodule

// File: tb/tb_rx_5b4b_deframer.sv
// Self-checking bench for rx_5b4b_deframer: three instances (byte words with MAX_LEN=4,
// 16-bit words, byte words with default length), table-driven frames plus hand-written corners.
module tb_rx_5b4b_deframer;
  typedef enum int {K_DATA, K_EOF, K_ERR, K_EOF_ERR} kind_t;
  typedef struct {
    kind_t       kind;
    logic [15:0] data;
    logic        sof;
    logic [2:0]  code;
    int          wc;
  } evt_t;
  typedef struct {
    int          nb;
    logic [47:0] bytes;
    logic [9:0]  term;
    kind_t       kind;
    logic [2:0]  code;
    int          wc;
  } vec_t;

  localparam logic [9:0] P_JK  = 10'b11000_10001;
  localparam logic [9:0] P_TT  = 10'b01101_01101;
  localparam logic [9:0] P_II  = 10'b11111_11111;
  localparam logic [9:0] P_BAD = 10'b00000_00000;
  localparam logic [9:0] P_AI  = 10'b10110_11111;
  localparam int MAX_A = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bit_in = 1'b0;
  logic bv = 1'b0;
  logic rx_en = 1'b1;
  int   sel = 0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_bit_cyc = 0;
  int   data_cyc[3];
  int   eof_cyc[3];
  int   err_cyc[3];
  logic [4:0] enc[16];
  evt_t exp_q[3][$];
  vec_t vecs[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        bv_v[3];
  logic        lockv[3], framev[3], dv[3], sofv[3], eofv[3], errv[3];
  logic [2:0]  ecode[3];
  logic [15:0] dout[3];
  logic [8:0]  wcnt[3];
  logic [7:0]  dout_a, dout_c;
  logic [15:0] dout_b;
  logic [2:0]  wcnt_a;
  logic [8:0]  wcnt_b, wcnt_c;

  assign bv_v[0] = bv && (sel == 0);
  assign bv_v[1] = bv && (sel == 1);
  assign bv_v[2] = bv && (sel == 2);
  assign dout[0] = {8'h00, dout_a};
  assign dout[1] = dout_b;
  assign dout[2] = {8'h00, dout_c};
  assign wcnt[0] = {6'd0, wcnt_a};
  assign wcnt[1] = wcnt_b;
  assign wcnt[2] = wcnt_c;

  rx_5b4b_deframer #(.NIB_PER_WORD(2), .MAX_LEN(MAX_A), .TO_CYC(64)) u_dut_a (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_vld(bv_v[0]), .rx_en(rx_en),
    .lock(lockv[0]), .frame(framev[0]), .data_o(dout_a), .data_vld(dv[0]), .sof(sofv[0]),
    .eof(eofv[0]), .err(errv[0]), .err_code(ecode[0]), .word_cnt(wcnt_a));

  rx_5b4b_deframer #(.NIB_PER_WORD(4), .MAX_LEN(256), .TO_CYC(64)) u_dut_b (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_vld(bv_v[1]), .rx_en(rx_en),
    .lock(lockv[1]), .frame(framev[1]), .data_o(dout_b), .data_vld(dv[1]), .sof(sofv[1]),
    .eof(eofv[1]), .err(errv[1]), .err_code(ecode[1]), .word_cnt(wcnt_b));

  rx_5b4b_deframer #(.NIB_PER_WORD(2), .MAX_LEN(256), .TO_CYC(64)) u_dut_c (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_vld(bv_v[2]), .rx_en(rx_en),
    .lock(lockv[2]), .frame(framev[2]), .data_o(dout_c), .data_vld(dv[2]), .sof(sofv[2]),
    .eof(eofv[2]), .err(errv[2]), .err_code(ecode[2]), .word_cnt(wcnt_c));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int d, input kind_t k, input logic [15:0] data, input logic s,
                      input logic [2:0] code, input int wc);
    evt_t e;
    e.kind = k; e.data = data; e.sof = s; e.code = code; e.wc = wc;
    exp_q[d].push_back(e);
  endtask

  function automatic logic [9:0] pair_of(input logic [7:0] b);
    return {enc[b[7:4]], enc[b[3:0]]};
  endfunction

  task automatic send_bit(input logic b);
    bit_in = b;
    bv = 1'b1;
    @(posedge clk); #1;
    bv = 1'b0;
    last_bit_cyc = cyc;
    repeat ($urandom_range(0, 1)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_pair(input logic [9:0] p);
    for (int i = 9; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic run_frame(input int d, input logic [7:0] bytes[$], input logic [9:0] term);
    sel = d;
    send_pair(P_II);
    send_pair(P_JK);
    foreach (bytes[i]) send_pair(pair_of(bytes[i]));
    send_pair(term);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (exp_q[d].size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    check($sformatf("d%0d_drain_pending", d), exp_q[d].size(), 0);
  endtask

  function automatic vec_t mk(input int nb, input logic [47:0] bytes, input logic [9:0] term,
                              input kind_t k, input logic [2:0] code, input int wc);
    vec_t v;
    v.nb = nb; v.bytes = bytes; v.term = term; v.kind = k; v.code = code; v.wc = wc;
    return v;
  endfunction

  // Scoreboard: every output event is matched in order against the expected queue.
  evt_t  m_e;
  kind_t m_k;
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        if (dv[d] || eofv[d] || errv[d]) begin
          if (dv[d])                       m_k = K_DATA;
          else if (eofv[d] && errv[d])     m_k = K_EOF_ERR;
          else if (eofv[d])                m_k = K_EOF;
          else                             m_k = K_ERR;
          if (dv[d])   data_cyc[d] = cyc;
          if (eofv[d]) eof_cyc[d]  = cyc;
          if (errv[d]) err_cyc[d]  = cyc;
          if (exp_q[d].size() == 0) begin
            check($sformatf("d%0d_unexpected_dv_eof_err", d), {dv[d], eofv[d], errv[d]}, 0);
          end else begin
            m_e = exp_q[d].pop_front();
            check($sformatf("d%0d_event_kind", d), m_k, m_e.kind);
            if (m_e.kind == K_DATA) begin
              check($sformatf("d%0d_data_o", d), dout[d], m_e.data);
              check($sformatf("d%0d_sof", d), sofv[d], m_e.sof);
            end
            if (m_e.kind == K_ERR || m_e.kind == K_EOF_ERR)
              check($sformatf("d%0d_err_code", d), ecode[d], m_e.code);
            if (m_e.wc >= 0)
              check($sformatf("d%0d_word_cnt", d), wcnt[d], m_e.wc);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] nib_tab[16];
    for (int i = 0; i < 16; i++) nib_tab[i] = 8'(i);
    enc[0]  = 5'b11110; enc[1]  = 5'b01001; enc[2]  = 5'b10100; enc[3]  = 5'b10101;
    enc[4]  = 5'b01010; enc[5]  = 5'b01011; enc[6]  = 5'b01110; enc[7]  = 5'b01111;
    enc[8]  = 5'b10010; enc[9]  = 5'b10011; enc[10] = 5'b10110; enc[11] = 5'b10111;
    enc[12] = 5'b11010; enc[13] = 5'b11011; enc[14] = 5'b11100; enc[15] = 5'b11101;

    vecs[0] = mk(1, 48'hA5_0000000000, P_TT,  K_EOF, 3'd0, 1);
    vecs[1] = mk(0, 48'h0,             P_TT,  K_EOF, 3'd0, 0);
    vecs[2] = mk(1, 48'hA5_0000000000, P_II,  K_ERR, 3'd3, 1);
    vecs[3] = mk(5, 48'h0102030405_00, P_TT,  K_ERR, 3'd4, 4);
    vecs[4] = mk(1, 48'h7E_0000000000, P_BAD, K_ERR, 3'd1, 1);
    vecs[5] = mk(1, 48'hC3_0000000000, P_AI,  K_ERR, 3'd3, 1);
    vecs[6] = mk(3, 48'hF0C396_000000, P_TT,  K_EOF, 3'd0, 3);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_a", {lockv[0], framev[0], dv[0], sofv[0], eofv[0], errv[0],
                              ecode[0], wcnt[0], dout[0]}, 0);
    check("reset_outputs_b", {lockv[1], framev[1], ecode[1], wcnt[1], dout[1]}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven frames on the MAX_LEN=4 byte instance
    for (int i = 0; i < 7; i++) begin
      q = {};
      for (int k = 0; k < vecs[i].nb; k++) begin
        q.push_back(vecs[i].bytes[47 - 8*k -: 8]);
        if (k < MAX_A) push(0, K_DATA, {8'h00, vecs[i].bytes[47 - 8*k -: 8]}, k == 0, 3'd0, k + 1);
      end
      push(0, vecs[i].kind, 16'h0, 1'b0, vecs[i].code, vecs[i].wc);
      run_frame(0, q, vecs[i].term);
      drain(0);
      check($sformatf("vec%0d_frame_after", i), {framev[0], lockv[0]}, 0);
      if (vecs[i].kind == K_EOF)
        check($sformatf("vec%0d_eof_latency", i), eof_cyc[0], last_bit_cyc);
      else
        check($sformatf("vec%0d_err_code_held", i), ecode[0], vecs[i].code);
    end

    // JK inside a frame: code 2, then a fresh frame starts immediately
    push(0, K_DATA, 16'hFF, 1'b1, 3'd0, 1);
    push(0, K_DATA, 16'h0F, 1'b0, 3'd0, 2);
    push(0, K_ERR,  16'h0,  1'b0, 3'd2, 0);
    sel = 0;
    send_pair(P_II);
    send_pair(P_JK);
    send_pair(pair_of(8'hFF));
    send_pair(pair_of(8'h0F));
    send_pair(P_JK);
    @(posedge clk); #1;
    check("jk_restart_frame_held", {framev[0], lockv[0]}, 2'b11);
    push(0, K_DATA, 16'h99, 1'b1, 3'd0, 1);
    push(0, K_EOF,  16'h0,  1'b0, 3'd0, 1);
    send_pair(pair_of(8'h99));
    send_pair(P_TT);
    drain(0);

    // Idle-bit timeout: 64 clks without bit_vld after the last bit
    push(0, K_DATA, 16'hA5, 1'b1, 3'd0, 1);
    push(0, K_ERR,  16'h0,  1'b0, 3'd6, 1);
    sel = 0;
    send_pair(P_II);
    send_pair(P_JK);
    send_pair(pair_of(8'hA5));
    drain(0);
    check("timeout_distance", err_cyc[0] - data_cyc[0], 64);
    check("timeout_lock_frame", {lockv[0], framev[0]}, 0);

    // rx_en low on the bit that would complete a pair: silent abort
    push(0, K_DATA, 16'h5A, 1'b1, 3'd0, 1);
    sel = 0;
    send_pair(P_II);
    send_pair(P_JK);
    send_pair(pair_of(8'h5A));
    for (int i = 9; i >= 1; i--) send_bit(pair_of(8'h3C) >> i);
    rx_en = 1'b0;
    send_bit(pair_of(8'h3C) & 10'h001);
    rx_en = 1'b1;
    drain(0);
    check("rx_en_abort_lock_frame", {lockv[0], framev[0]}, 0);

    // Asynchronous reset mid-frame
    sel = 0;
    send_pair(P_II);
    send_pair(P_JK);
    for (int i = 9; i >= 5; i--) send_bit(pair_of(8'h12) >> i);
    check("pre_reset_frame", framev[0], 1'b1);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", {lockv[0], framev[0], ecode[0], wcnt[0], dout[0]}, 0);
    @(negedge clk);
    reset = 1'b0;
    push(0, K_DATA, 16'h3C, 1'b1, 3'd0, 1);
    push(0, K_EOF,  16'h0,  1'b0, 3'd0, 1);
    q = {};
    q.push_back(8'h3C);
    run_frame(0, q, P_TT);
    drain(0);

    // 16-bit words: TT mid-word gives code 5, then a clean two-byte word
    push(1, K_ERR, 16'h0, 1'b0, 3'd5, 0);
    q = {};
    q.push_back(8'h12);
    run_frame(1, q, P_TT);
    drain(1);
    push(1, K_DATA, 16'h1234, 1'b1, 3'd0, 1);
    push(1, K_EOF,  16'h0,    1'b0, 3'd0, 1);
    q.push_back(8'h34);
    run_frame(1, q, P_TT);
    drain(1);
    check("b_eof_latency", eof_cyc[1], last_bit_cyc);

    // "123456789" with CRC bytes 29 B1 (good) and 29 B0 (bad)
    for (int pass = 0; pass < 2; pass++) begin
      q = {};
      for (int k = 1; k <= 9; k++) q.push_back(8'h30 | nib_tab[k]);
      q.push_back(8'h29);
      q.push_back(pass == 0 ? 8'hB1 : 8'hB0);
      foreach (q[k]) push(2, K_DATA, {8'h00, q[k]}, k == 0, 3'd0, k + 1);
`ifdef RX_CRC_EN
      if (pass == 0) push(2, K_EOF, 16'h0, 1'b0, 3'd0, 11);
      else           push(2, K_EOF_ERR, 16'h0, 1'b0, 3'd7, 11);
`else
      push(2, K_EOF, 16'h0, 1'b0, 3'd0, 11);
`endif
      run_frame(2, q, P_TT);
      drain(2);
    end

    for (int d = 0; d < 3; d++)
      check($sformatf("d%0d_final_queue", d), exp_q[d].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_5b4b_deframer.md
Name: rx_5b4b_deframer

Overview:
Parametrised successor to the single-channel 5B/4B receiver. It consumes the recovered bit stream from the phase-sync block, one bit per strobe, and aligns on the J/K start delimiter. It decodes 5B symbols into DATA_W-bit words and frames them with sof/eof. It adds a maximum-length check, an idle-bit timeout and coded error reporting, and sits between the bit-phase sync and the bus protocol layer.

Parameters:
NIB_PER_WORD, 2, nibbles per output word; legal values 2, 4, 8; DATA_W = 4*NIB_PER_WORD.
MAX_LEN, 256, maximum data words per frame.
TO_CYC, 64, clk cycles without bit_vld inside a frame before timeout.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
bit_in  in  1  recovered serial bit
bit_vld  in  1  bit_in valid strobe, at most one per clk
rx_en  in  1  receive enable
lock  out  1  phase lock hold to the phase-sync block
frame  out  1  frame in progress
data_o  out  DATA_W  decoded word
data_vld  out  1  data_o valid, 1-cycle pulse
sof  out  1  first word of frame, coincident with data_vld
eof  out  1  frame end pulse
err  out  1  error pulse
err_code  out  3  error cause; held until the next JK
word_cnt  out  clog2(MAX_LEN+1)  words delivered in the current or last frame

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset values: all outputs 0; shift register sr[9:0] = 10'h3FF.
- Shift: on bit_vld, sr <= {sr[8:0], bit_in}. Bits arrive MSB first; the first symbol of a pair is the high nibble.
- Symbols: J/K = sr == 11000_10001; T/T = 01101_01101; I = 11111. Data symbols use the standard 4B5B table (0=11110 ... F=11101).
- States:
  - IDLE: on JK go to RECV; lock=1, frame=1, word_cnt=0, err_code=0, pair counter and nibble index cleared.
  - RECV: a 10-bit pair completes every 10 bit_vld strobes after JK. At pair completion:
    - TT with nibble index 0: eof=1, go to IDLE.
    - TT mid-word: err code 5, go to IDLE.
    - JK: err code 2, then restart directly as a new frame (stay RECV, counters cleared).
    - Any I symbol: err code 3, go to IDLE.
    - Any non-data symbol: err code 1, go to IDLE.
    - Two data symbols: append 8 bits to the word. When NIB_PER_WORD nibbles are collected, pulse data_vld; sof on the first word; word_cnt++.
    - Word number MAX_LEN+1: not output; err code 4, go to IDLE.
- Timeout: a counter runs in RECV and clears on each bit_vld. Reaching TO_CYC gives err code 6, go to IDLE.
- Exiting to IDLE: lock=0, frame=0 the cycle after the decision.
- Latency: data_vld, eof and err are registered 1 clk after the bit_vld that completes the pair.
- Empty frame (JK followed immediately by TT): eof=1, word_cnt=0, no data_vld, no err.
- rx_en low: synchronous abort to IDLE with frame=0 and lock=0. No eof or err. It overrides a same-cycle bit_vld event.
- Reset mid-frame: immediate return to reset values; a partial word is discarded.
- err and eof are never both 1, except for a CRC failure (see below).

Optional Feature:
RX_CRC_EN:
- Defined: CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, non-reflected) runs over every delivered word, MSB first, including the two trailing CRC bytes.
- At a clean TT the residue must be 0x0000. Otherwise eof=1 and err=1 with code 7 in the same cycle.
- Undefined: no CRC logic is built and code 7 is never produced.

Test Plan:
- NIB_PER_WORD=2; bits 1100010001 1011001011 0110101101 -> one pulse data_o=0xA5 with sof=1; eof 1 clk after the last T bit; word_cnt=1; err=0.
- NIB_PER_WORD=4; JK, symbols for 0x12 then 0x34, TT -> single data_vld with data_o=0x1234; eof; word_cnt=1.
- JK, 0xA5, then pair 11111_11111 -> data 0xA5 delivered; err=1, code 3; frame=0 next clk; no eof.
- MAX_LEN=4; JK, 5 bytes, TT -> 4 data_vld pulses; err code 4 on the fifth pair; no eof.
- JK, 1 byte, bit_vld stalls for 64 clks -> err code 6 at cycle 64; lock=0; rx_en low mid-frame gives no err or eof.
- RX_CRC_EN: "123456789" plus 0x29, 0xB1 -> eof, err=0. Same frame with 0x29, 0xB0 -> eof and err code 7.
